// File: rtl/spectrum_reader.sv
// Spectrum reader: converts a 16-band signed frame into log2 display levels,
// one band per cycle. Optional peak-hold/decay is enabled by SPECTRUM_PEAK_HOLD_EN.
module spectrum_reader #(
    parameter int unsigned DECAY_FRAMES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0][15:0] i_data,
    input  logic              i_data_done,
    input  logic [3:0]        i_rd_band,
    output logic [3:0]        o_rd_level,
    output logic [3:0]        o_rd_peak,
    output logic              o_frame_valid,
    output logic              o_busy,
    output logic              o_overrun
);

    if (DECAY_FRAMES < 1 || DECAY_FRAMES > 15) begin : g_bad_decay
        $error("spectrum_reader: DECAY_FRAMES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROC,
        S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0][15:0] shadow_q, shadow_d;
    logic [15:0][3:0]  work_q, work_d;
    logic [15:0][3:0]  level_q, level_d;
    logic              frame_valid_q, frame_valid_d;
    logic              overrun_q, overrun_d;

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam logic [3:0] HOLD_RELOAD = 4'(DECAY_FRAMES);

    logic [15:0][3:0]  peak_q, peak_d;
    logic [15:0][3:0]  hold_q, hold_d;
`endif

    // Level is the index of the highest set magnitude bit plus one.
    function automatic logic [3:0] band_level(input logic [15:0] x);
        logic [15:0] mag;
        logic [3:0]  lvl;
        mag = x[15] ? (~x + 16'd1) : x;
        if (mag[15]) begin
            mag = 16'h7fff;
        end
        lvl = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (mag[i]) begin
                lvl = 4'(i + 1);
            end
        end
        return lvl;
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        work_d        = work_q;
        level_d       = level_q;
        frame_valid_d = 1'b0;
        overrun_d     = overrun_q;
`ifdef SPECTRUM_PEAK_HOLD_EN
        peak_d        = peak_q;
        hold_d        = hold_q;
`endif

        if (i_data_done && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_data_done) begin
                    shadow_d = i_data;
                    cnt_d    = '0;
                    state_d  = S_PROC;
                end
            end
            S_PROC: begin
                work_d[cnt_q] = band_level(shadow_q[cnt_q]);
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                level_d       = work_q;
                frame_valid_d = 1'b1;
                state_d       = S_IDLE;
`ifdef SPECTRUM_PEAK_HOLD_EN
                for (int unsigned b = 0; b < 16; b++) begin
                    if (work_q[b] >= peak_q[b]) begin
                        peak_d[b] = work_q[b];
                        hold_d[b] = HOLD_RELOAD;
                    end else if (hold_q[b] == 4'd0) begin
                        peak_d[b] = ((peak_q[b] - 4'd1) > work_q[b]) ? (peak_q[b] - 4'd1) : work_q[b];
                        hold_d[b] = HOLD_RELOAD;
                    end else begin
                        hold_d[b] = hold_q[b] - 4'd1;
                    end
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            work_q        <= '0;
            level_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef SPECTRUM_PEAK_HOLD_EN
            peak_q        <= '0;
            hold_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            work_q        <= work_d;
            level_q       <= level_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
`ifdef SPECTRUM_PEAK_HOLD_EN
            peak_q        <= peak_d;
            hold_q        <= hold_d;
`endif
        end
    end

    assign o_rd_level    = level_q[i_rd_band];
`ifdef SPECTRUM_PEAK_HOLD_EN
    assign o_rd_peak     = peak_q[i_rd_band];
`else
    assign o_rd_peak     = level_q[i_rd_band];
`endif
    assign o_frame_valid = frame_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_spectrum_reader.sv
// Self-checking bench for spectrum_reader: frame-level reference model plus
// directed literal checks; peak-hold checks active with SPECTRUM_PEAK_HOLD_EN.
module tb_spectrum_reader;

    logic              i_clk;
    logic              i_rst_n;
    logic [15:0][15:0] i_data;
    logic              i_data_done;
    logic [3:0]        i_rd_band;
    logic [3:0]        o_rd_level;
    logic [3:0]        o_rd_peak;
    logic              o_frame_valid;
    logic              o_busy;
    logic              o_overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_band = 1'b1;

    spectrum_reader #(.DECAY_FRAMES(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_data        (i_data),
        .i_data_done   (i_data_done),
        .i_rd_band     (i_rd_band),
        .o_rd_level    (o_rd_level),
        .o_rd_peak     (o_rd_peak),
        .o_frame_valid (o_frame_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame granularity) ----------------
    function automatic int lvl_of(input logic [15:0] x);
        int v, m, l;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        l = 0;
        while ((1 << l) <= m) l++;
        return l;
    endfunction

    function automatic int next_peak(input int pk, input int hold, input int lv);
        if (lv >= pk) return lv;
        if (hold == 0) return (pk - 1 > lv) ? pk - 1 : lv;
        return pk;
    endfunction

    function automatic int next_hold(input int pk, input int hold, input int lv);
        if (lv >= pk || hold == 0) return 4;
        return hold - 1;
    endfunction

    int                m_cnt = 0;
    logic [15:0][15:0] m_pend;
    int                m_lvl [16];
    int                m_pk  [16];
    int                m_hold[16];
    bit                m_valid = 1'b0;
    bit                m_ovr   = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                m_lvl[k]  <= 0;
                m_pk[k]   <= 0;
                m_hold[k] <= 0;
            end
        end else begin
            m_valid <= (m_cnt == 1);
            if (i_data_done && m_cnt != 0) m_ovr <= 1'b1;
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            else if (i_data_done) begin
                m_cnt  <= 17;
                m_pend <= i_data;
            end
            if (m_cnt == 1) begin
                for (int k = 0; k < 16; k++) begin
                    m_lvl[k] <= lvl_of(m_pend[k]);
`ifdef SPECTRUM_PEAK_HOLD_EN
                    m_pk[k]   <= next_peak(m_pk[k], m_hold[k], lvl_of(m_pend[k]));
                    m_hold[k] <= next_hold(m_pk[k], m_hold[k], lvl_of(m_pend[k]));
`else
                    m_pk[k]   <= lvl_of(m_pend[k]);
`endif
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        check("busy",        int'(o_busy),        int'(m_cnt != 0));
        check("frame_valid", int'(o_frame_valid), int'(m_valid));
        check("overrun",     int'(o_overrun),     int'(m_ovr));
        check("rd_level",    int'(o_rd_level),    m_lvl[i_rd_band]);
        check("rd_peak",     int'(o_rd_peak),     m_pk[i_rd_band]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_band) i_rd_band = 4'($urandom_range(0, 15));
    endtask

    task automatic pulse(input logic [15:0][15:0] d);
        i_data      = d;
        i_data_done = 1'b1;
        tick();
        i_data_done = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after the accepting edge) of o_frame_valid.
    task automatic wait_valid(input string name, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            if (o_busy) busy_n++;
            if (o_frame_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: frame_valid timeout, got none, expected within 40 cycles", name);
        end
    endtask

    task automatic read_band(input string name, input int k, input int exp_lvl, input int exp_pk);
        tick();
        i_rd_band = 4'(k);
        @(negedge i_clk);
        check({name, "_level"}, int'(o_rd_level), exp_lvl);
        check({name, "_peak"},  int'(o_rd_peak),  exp_pk);
    endtask

    function automatic logic [15:0][15:0] rand_frame();
        logic [15:0][15:0] f;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0:       f[k] = 16'h0000;
                1:       f[k] = 16'h8000;
                2:       f[k] = 16'($urandom);
                default: f[k] = 16'($urandom) >> $urandom_range(0, 15);
            endcase
        end
        return f;
    endfunction

    logic [15:0][15:0] frm;
    int lat, busy_n;
    int pk_seq[9] = '{10, 10, 10, 10, 10, 9, 9, 9, 9};

    initial begin
        i_rst_n     = 1'b1;
        i_data      = '0;
        i_data_done = 1'b0;
        i_rd_band   = '0;
        #1 i_rst_n  = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_busy",    int'(o_busy), 0);
        check("reset_valid",   int'(o_frame_valid), 0);
        check("reset_overrun", int'(o_overrun), 0);
        check("reset_level",   int'(o_rd_level), 0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Powers of two plus the saturating minimum.
        for (int k = 0; k < 15; k++) frm[k] = 16'(1 << k);
        frm[15] = 16'h8000;
        pulse(frm);
        wait_valid("pow2", lat, busy_n);
        check("pow2_latency", lat - 1, 17);
        check("pow2_busy_cycles", busy_n, 17);
        // Back-to-back acceptance at the earliest edge.
        i_data      = '0;
        i_data_done = 1'b1;
        @(posedge i_clk);
        #1 i_data_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
            read_band("pow2", k, (k < 15) ? k + 1 : 15, (k < 15) ? k + 1 : 15);
`else
            read_band("pow2", k, (k < 15) ? k + 1 : 15, (k < 15) ? k + 1 : 15);
`endif
        end
        wait_valid("zeros", lat, busy_n);
        check("zeros_b2b_accept", int'(o_busy), 0);
        read_band("zeros", 5, 0, m_pk[5]);
        check("no_overrun_b2b", int'(o_overrun), 0);

        // Single negative band.
        tick();
        frm    = '0;
        frm[3] = 16'hfffb;
        pulse(frm);
        wait_valid("neg5", lat, busy_n);
        read_band("neg5_b3", 3, 3, m_pk[3]);
        read_band("neg5_b2", 2, 0, m_pk[2]);
        read_band("neg5_b4", 4, 0, m_pk[4]);

        // Overrun: second pulse five cycles into a frame is dropped.
        tick();
        for (int k = 0; k < 16; k++) frm[k] = 16'd100;
        pulse(frm);
        repeat (4) tick();
        for (int k = 0; k < 16; k++) frm[k] = 16'h7fff;
        pulse(frm);
        wait_valid("overrun", lat, busy_n);
        check("overrun_flag", int'(o_overrun), 1);
        read_band("overrun_b0", 0, 7, m_pk[0]);
        read_band("overrun_b9", 9, 7, m_pk[9]);

        // Reset at band 7 abandons the frame.
        tick();
        pulse(rand_frame());
        repeat (7) tick();
        i_rst_n = 1'b0;
        for (int k = 0; k < 16; k++) read_band("midreset", k, 0, 0);
        check("midreset_overrun", int'(o_overrun), 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        frm = rand_frame();
        pulse(frm);
        wait_valid("after_reset", lat, busy_n);
        check("after_reset_latency", lat - 1, 17);

`ifdef SPECTRUM_PEAK_HOLD_EN
        // Peak hold and decay on band 0.
        tick();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        frm    = '0;
        frm[0] = 16'd512;
        pulse(frm);
        wait_valid("peak0", lat, busy_n);
        read_band("peak_f0", 0, 10, pk_seq[0]);
        for (int f = 1; f < 9; f++) begin
            tick();
            pulse('0);
            wait_valid("peak_decay", lat, busy_n);
            read_band("peak_decay", 0, 0, pk_seq[f]);
        end
`endif

        // Randomized frames with random gaps and occasional dropped pulses.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(1, 4)) tick();
            pulse(rand_frame());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 12)) tick();
                pulse(rand_frame());
            end
            wait_valid("random", lat, busy_n);
        end
        rand_band = 1'b0;
        for (int k = 0; k < 16; k++) read_band("sweep", k, m_lvl[k], m_pk[k]);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
